// File: rtl/topfft_pkg.sv
// Shared constants, encodings and token type for the 128-point FFT frame sequencer.
package topfft_pkg;

    localparam int unsigned N     = 128;
    localparam int unsigned PAR   = 4;
    localparam int unsigned B     = N / PAR;
    localparam int unsigned IDX_W = $clog2(B);

    localparam int unsigned LAT0  = 10;
    localparam int unsigned LAT1  = 12;
    localparam int unsigned LAT2  = 14;
    localparam int unsigned LAT3  = 4;
    localparam int unsigned LMAX  = LAT0 + LAT1 + LAT2 + LAT3;
    localparam int unsigned POS_W = $clog2(LMAX);

    typedef enum logic [1:0] {
        TAP_SAT0 = 2'd0,
        TAP_SAT1 = 2'd1,
        TAP_SAT2 = 2'd2,
        TAP_SAT3 = 2'd3
    } tap_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic             valid;
        logic             sof;
        logic [IDX_W-1:0] idx;
    } token_t;

    // Line position read for a tap: cumulative latency minus one register stage.
    function automatic logic [POS_W-1:0] tap_pos(input tap_e tap);
        case (tap)
            TAP_SAT0: tap_pos = POS_W'(LAT0 - 1);
            TAP_SAT1: tap_pos = POS_W'(LAT0 + LAT1 - 1);
            TAP_SAT2: tap_pos = POS_W'(LAT0 + LAT1 + LAT2 - 1);
            default:  tap_pos = POS_W'(LMAX - 1);
        endcase
    endfunction

endpackage

// File: rtl/topfft_token_line.sv
// In-flight token shift register with partial-frame invalidate and a variable read tap.
module topfft_token_line
    import topfft_pkg::*;
#(
    parameter int unsigned DEPTH   = LMAX,
    parameter int unsigned POS_W_P = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  token_t             in_tok,
    input  logic               inv,
    input  logic [IDX_W-1:0]   inv_cnt,
    input  logic [POS_W_P-1:0] tap,
    output token_t             tap_tok_c,
    output logic               any_valid_c,
    output logic               pre_valid_c
);

    token_t line_q [DEPTH];
    token_t line_n [DEPTH];

    // Shift one entry per clock; on invalidate, the newest inv_cnt entries are cleared as they move.
    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            line_n[k] = '0;
        end
        line_n[0] = in_tok;
        for (int k = 1; k < int'(DEPTH); k++) begin
            line_n[k] = line_q[k-1];
            if (inv && ((k - 1) < int'(inv_cnt))) begin
                line_n[k] = '0;
            end
        end
    end

    // Line register; reset flushes every token.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                line_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                line_q[k] <= line_n[k];
            end
        end
    end

    // Tap read plus occupancy flags for the whole line and for the part upstream of the tap.
    always_comb begin
        tap_tok_c   = '0;
        any_valid_c = 1'b0;
        pre_valid_c = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (POS_W_P'(k) == tap) begin
                tap_tok_c = line_q[k];
            end
            if (line_q[k].valid) begin
                any_valid_c = 1'b1;
                if (POS_W_P'(k) < tap) begin
                    pre_valid_c = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/topfft_seq_ctrl.sv
// Frame sequencer: input beat counting, stage enable, in-flight tracking and output tap control.
module topfft_seq_ctrl
    import topfft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [1:0]       i_tap_sel,
    input  logic             i_tap_wr,
    input  logic             i_err_clr,
    output logic             o_enable,
    output logic [IDX_W-1:0] o_in_idx,
    output logic [1:0]       o_tap_sel,
    output logic             o_out_valid,
    output logic             o_out_sof,
    output logic [IDX_W-1:0] o_out_idx,
    output logic             o_busy,
    output logic [1:0]       o_err
);

    state_e           state_q, state_n;
    tap_e             tap_q, tap_n;
    logic [IDX_W-1:0] cnt_q, cnt_n;
    logic [1:0]       err_q, err_n;

    logic             first_c;
    logic             gap_c;
    token_t           in_tok_c;
    token_t           tap_tok_c;
    logic             any_valid_c;
    logic             pre_valid_c;

    // Input beat bookkeeping: frame start detect, gap detect and the token entered into the line.
    always_comb begin
        first_c        = (cnt_q == '0);
        gap_c          = !i_valid && !first_c;
        in_tok_c       = '0;
        in_tok_c.valid = i_valid;
        in_tok_c.sof   = i_valid && first_c;
        in_tok_c.idx   = i_valid ? cnt_q : '0;
        cnt_n          = '0;
        if (i_valid) begin
            cnt_n = (cnt_q == IDX_W'(B - 1)) ? '0 : IDX_W'(cnt_q + 1'b1);
        end
    end

    topfft_token_line #(
        .DEPTH   (LMAX),
        .POS_W_P (POS_W)
    ) u_line (
        .clk         (clk),
        .rst         (rst),
        .in_tok      (in_tok_c),
        .inv         (gap_c),
        .inv_cnt     (cnt_q),
        .tap         (tap_pos(tap_q)),
        .tap_tok_c   (tap_tok_c),
        .any_valid_c (any_valid_c),
        .pre_valid_c (pre_valid_c)
    );

    // Next state, tap select update and sticky error accumulation.
    always_comb begin
        state_n = state_q;
        tap_n   = tap_q;
        err_n   = i_err_clr ? 2'b00 : err_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_n = FILL;
                end
            end
            FILL: begin
                if (tap_tok_c.valid) begin
                    state_n = RUN;
                end else if (!i_valid && !any_valid_c) begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (!i_valid && !pre_valid_c) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (i_valid) begin
                    state_n = RUN;
                end else if (!any_valid_c) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // The line is empty only in IDLE, so a tap change can never split a frame.
        if (i_tap_wr) begin
            if (state_q == IDLE) begin
                tap_n = tap_e'(i_tap_sel);
            end else begin
                err_n[1] = 1'b1;
            end
        end

        if (gap_c) begin
            err_n[0] = 1'b1;
        end
    end

    // State, counter, tap select and error registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            tap_q   <= TAP_SAT3;
            cnt_q   <= '0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_n;
            tap_q   <= tap_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
        end
    end

    // Output drive: enable/index follow the live input, output beat follows the selected tap.
    always_comb begin
        o_enable    = i_valid && first_c;
        o_in_idx    = cnt_q;
        o_tap_sel   = tap_q;
        o_out_valid = tap_tok_c.valid;
        o_out_sof   = tap_tok_c.valid && tap_tok_c.sof;
        o_out_idx   = tap_tok_c.idx;
        o_busy      = (state_q != IDLE);
        o_err       = err_q;
    end

endmodule
